// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Walks an (x, y) raster covering
// the active area plus front porch, sync and back porch in both directions,
// and produces registered, mutually aligned sync, display-enable and
// line/frame start strobes for the pixel renderer and the DAC/pin stage.
//
// A pixel clock enable (pix_ce) lets one fast system clock drive any slower
// pixel rate: nothing in the raster moves on a clk edge with pix_ce low.
// A run/stop control lets the raster finish the frame it is drawing and then
// park at the last position (H_TOTAL-1, V_TOTAL-1), so that restarting
// always begins a clean frame at (0, 0).
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   pix_ce       pixel clock enable
//   run          1 = keep generating frames, 0 = park at the end of the frame
//   x, y         current pixel column / line
//   hsync        horizontal sync, H_POL level while in the sync region
//   vsync        vertical sync, V_POL level while in the sync region
//   de           display enable, high inside the active area
//   line_start   one-clk strobe when the raster steps to x = 0
//   frame_start  one-clk strobe when the raster steps to (0, 0)
//   busy         high whenever the raster is not parked
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int XW       = 10,
   parameter int YW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_ce,
   input  logic          run,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          line_start,
   output logic          frame_start,
   output logic          busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Region boundaries are kept as inclusive "last" positions so that none
   // of them can exceed TOTAL-1, which always fits in the counter width even
   // when the raster exactly fills 2^XW or 2^YW.
   localparam logic [XW-1:0] X_LAST      = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT_LAST  = XW'(H_ACTIVE - 1);
   localparam logic [XW-1:0] X_HS_FIRST  = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] X_HS_LAST   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [YW-1:0] Y_LAST      = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_ACT_LAST  = YW'(V_ACTIVE - 1);
   localparam logic [YW-1:0] Y_VS_FIRST  = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] Y_VS_LAST   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          lineStart_q, lineStart_d;
   logic          frameStart_q, frameStart_d;
   logic          busy_q, busy_d;
   logic          atLineEnd;
   logic          atFrameEnd;

   // Position of the raster relative to its wrap points. atFrameEnd marks the
   // single position from which the next step would return to (0, 0); that is
   // also where a stop request parks the raster.
   always_comb begin
      atLineEnd  = (x_q == X_LAST);
      atFrameEnd = atLineEnd && (y_q == Y_LAST);
   end

   // State register. Kept apart from the raster registers so the FSM reads
   // as register / next-state / output. Reset always lands in IDLE, so a
   // reset in the middle of a frame leaves nothing behind and the next
   // frame after release begins at (0, 0).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and raster stepping. Everything holds on edges without
   // pix_ce, including the FSM, so a run change seen on such an edge simply
   // waits for the next enabled edge. RUN and STOPPING step the raster in
   // exactly the same way; the only difference is that STOPPING, when run is
   // still low at the final position, holds the counters instead of wrapping
   // and drops to IDLE. Seeing run high again in STOPPING returns to RUN
   // without disturbing the raster, so a stop request withdrawn within the
   // frame leaves the frame timing untouched. Leaving IDLE jumps straight to
   // (0, 0), which is exactly where the wrap from the parked position would
   // have gone, so both paths raise the same pair of strobes.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      lineStart_d  = 1'b0;
      frameStart_d = 1'b0;
      if (pix_ce) begin
         case (state_q)
            IDLE: begin
               if (run) begin
                  state_d      = RUN;
                  x_d          = '0;
                  y_d          = '0;
                  lineStart_d  = 1'b1;
                  frameStart_d = 1'b1;
               end
            end
            RUN, STOPPING: begin
               if ((state_q == STOPPING) && !run && atFrameEnd) begin
                  state_d = IDLE;
               end else begin
                  state_d = run ? RUN : STOPPING;
                  if (atLineEnd) begin
                     x_d         = '0;
                     lineStart_d = 1'b1;
                     if (atFrameEnd) begin
                        y_d          = '0;
                        frameStart_d = 1'b1;
                     end else begin
                        y_d = y_q + YW'(1);
                     end
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Output decode. Sync and display enable are decoded from the position the
   // raster is about to present, not the one it presents now, and then
   // registered alongside x/y. That way every output changes on the same edge
   // and describes the same pixel, with no one-cycle skew between the
   // counters and the decoded signals.
   always_comb begin
      hsync_d = ((x_d >= X_HS_FIRST) && (x_d <= X_HS_LAST)) ? H_POL : ~H_POL;
      vsync_d = ((y_d >= Y_VS_FIRST) && (y_d <= Y_VS_LAST)) ? V_POL : ~V_POL;
      de_d    = (x_d <= X_ACT_LAST) && (y_d <= Y_ACT_LAST);
      busy_d  = (state_d != IDLE);
   end

   // Raster and output registers. Reset parks the raster at the last
   // position with every strobe low and both syncs inactive, matching what
   // IDLE presents after a normal stop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q          <= X_LAST;
         y_q          <= Y_LAST;
         hsync_q      <= ~H_POL;
         vsync_q      <= ~V_POL;
         de_q         <= 1'b0;
         lineStart_q  <= 1'b0;
         frameStart_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         de_q         <= de_d;
         lineStart_q  <= lineStart_d;
         frameStart_q <= frameStart_d;
         busy_q       <= busy_d;
      end
   end

   // Every output comes straight from a register.
   always_comb begin
      x           = x_q;
      y           = y_q;
      hsync       = hsync_q;
      vsync       = vsync_q;
      de          = de_q;
      line_start  = lineStart_q;
      frame_start = frameStart_q;
      busy        = busy_q;
   end

endmodule
